// File: rtl/mat_fmt_streamer.sv
// mat_fmt_streamer: walks row-major matrices in storage and renders every
// element as right-aligned decimal ASCII on a valid/ready byte stream, with
// optional "k+1" CR LF headers in front of each matrix.
// Optional feature: define MAT_FMT_SIGNED_EN to render elements as
// two's-complement values (adds the SIGN state and the sign flag).
module mat_fmt_streamer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DIM_W  = 5,
  parameter int CNT_W  = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [3:0]        cfg_pad,
  input  logic              cfg_hdr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // ceil(DATA_W * log10(2)) in integer arithmetic: 10 digits for 32 bits.
  localparam int DIGITS = (DATA_W * 30103 + 99999) / 100000;
  localparam int NDW    = $clog2(DIGITS + 1);
  localparam int LTW    = $clog2(RD_LAT + 1);
  localparam int PW     = ADDR_W + DIM_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_CONV,
    S_HDR_DIG,
    S_HDR_CR,
    S_HDR_LF,
    S_RD_REQ,
    S_RD_WAIT,
    S_CONV,
    S_PAD,
`ifdef MAT_FMT_SIGNED_EN
    S_SIGN,
`endif
    S_DIGIT,
    S_SEP,
    S_EOL_CR,
    S_EOL_LF,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    rows_q, rows_d, cols_q, cols_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [3:0]          pad_q, pad_d;
  logic                hdr_q, hdr_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [DIM_W-1:0]    r_q, r_d, c_q, c_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [NDW-1:0]      ndig_q, ndig_d;
  logic [3:0]          pcnt_q, pcnt_d;
  logic [LTW-1:0]      lat_q, lat_d;
  logic                done_q, done_d, err_q, err_d;
  logic [3:0]          dig_q [DIGITS];
  logic [3:0]          dig_d [DIGITS];
  logic                neg;
`ifdef MAT_FMT_SIGNED_EN
  logic                neg_q, neg_d;
  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

  // Divider step shared by header and element conversion.
  logic [DATA_W-1:0] quo;
  logic [3:0]        rem4;
  logic [7:0]        fin_len, npad;
  logic              xfer;
  assign quo     = val_q / DATA_W'(10);
  assign rem4    = 4'(val_q % DATA_W'(10));
  // Field length once the digit being extracted now is counted.
  assign fin_len = 8'(ndig_q) + 8'd1 + 8'(neg);
  assign npad    = (8'(pad_q) > fin_len) ? (8'(pad_q) - fin_len) : 8'd0;
  assign xfer    = tx_valid & tx_ready;

  // Status and storage read port, decoded from the registered state.
  assign busy        = (state_q != S_IDLE);
  assign mem_rd_en   = (state_q == S_RD_REQ);
  assign mem_rd_addr = mem_rd_en ?
      ADDR_W'(PW'(base_q) + PW'(k_q) * PW'(rows_q) * PW'(cols_q)
              + PW'(r_q) * PW'(cols_q) + PW'(c_q)) : '0;
  assign done = done_q;
  assign err  = err_q;

  // Byte offered on the stream; depends only on registers, so it is held
  // stable for as long as the sink stalls.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_PAD, S_SEP: begin
        tx_valid = 1'b1;
        tx_data  = 8'h20;
      end
`ifdef MAT_FMT_SIGNED_EN
      S_SIGN: begin
        tx_valid = 1'b1;
        tx_data  = 8'h2D;
      end
`endif
      S_DIGIT, S_HDR_DIG: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'h0, dig_q[ndig_q - NDW'(1)]};
      end
      S_HDR_CR, S_EOL_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
      end
      S_HDR_LF, S_EOL_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
      end
      default: ;
    endcase
  end

  // Next-state logic: sequencing, counters and digit extraction.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    base_d  = base_q;
    count_d = count_q;
    pad_d   = pad_q;
    hdr_d   = hdr_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    val_d   = val_q;
    ndig_d  = ndig_q;
    pcnt_d  = pcnt_q;
    lat_d   = lat_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MAT_FMT_SIGNED_EN
    neg_d   = neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = cfg_rows;
          cols_d  = cfg_cols;
          base_d  = cfg_base;
          count_d = cfg_count;
          pad_d   = cfg_pad;
          hdr_d   = cfg_hdr;
          k_d     = '0;
          r_d     = '0;
          c_d     = '0;
          if (cfg_rows == '0 || cfg_cols == '0 || cfg_count == '0) begin
            state_d = S_DONE;
          end else if (cfg_hdr) begin
            val_d   = DATA_W'(1);
            ndig_d  = '0;
            state_d = S_HDR_CONV;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_HDR_CONV, S_CONV: begin
        dig_d[ndig_q] = rem4;
        val_d         = quo;
        ndig_d        = ndig_q + NDW'(1);
        if (quo == '0) begin
          if (state_q == S_HDR_CONV) begin
            state_d = S_HDR_DIG;
          end else begin
            pcnt_d = 4'(npad);
            if (npad != 8'd0) begin
              state_d = S_PAD;
            end else begin
`ifdef MAT_FMT_SIGNED_EN
              state_d = neg_q ? S_SIGN : S_DIGIT;
`else
              state_d = S_DIGIT;
`endif
            end
          end
        end
      end
      S_HDR_DIG: begin
        if (xfer) begin
          ndig_d = ndig_q - NDW'(1);
          if (ndig_q == NDW'(1)) state_d = S_HDR_CR;
        end
      end
      S_HDR_CR: if (xfer) state_d = S_HDR_LF;
      S_HDR_LF: if (xfer) state_d = S_RD_REQ;
      S_RD_REQ: begin
        lat_d   = LTW'(1);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == LTW'(RD_LAT)) begin
`ifdef MAT_FMT_SIGNED_EN
          neg_d = mem_rd_data[DATA_W-1];
          val_d = mem_rd_data[DATA_W-1] ? (~mem_rd_data + DATA_W'(1)) : mem_rd_data;
`else
          val_d = mem_rd_data;
`endif
          ndig_d  = '0;
          state_d = S_CONV;
        end else begin
          lat_d = lat_q + LTW'(1);
        end
      end
      S_PAD: begin
        if (xfer) begin
          pcnt_d = pcnt_q - 4'd1;
          if (pcnt_q == 4'd1) begin
`ifdef MAT_FMT_SIGNED_EN
            state_d = neg_q ? S_SIGN : S_DIGIT;
`else
            state_d = S_DIGIT;
`endif
          end
        end
      end
`ifdef MAT_FMT_SIGNED_EN
      S_SIGN: if (xfer) state_d = S_DIGIT;
`endif
      S_DIGIT: begin
        if (xfer) begin
          ndig_d = ndig_q - NDW'(1);
          if (ndig_q == NDW'(1)) begin
            state_d = (c_q == cols_q - DIM_W'(1)) ? S_EOL_CR : S_SEP;
          end
        end
      end
      S_SEP: begin
        if (xfer) begin
          c_d     = c_q + DIM_W'(1);
          state_d = S_RD_REQ;
        end
      end
      S_EOL_CR: if (xfer) state_d = S_EOL_LF;
      S_EOL_LF: begin
        if (xfer) begin
          c_d = '0;
          if (r_q != rows_q - DIM_W'(1)) begin
            r_d     = r_q + DIM_W'(1);
            state_d = S_RD_REQ;
          end else begin
            r_d = '0;
            if (k_q != count_q - CNT_W'(1)) begin
              k_d = k_q + CNT_W'(1);
              if (hdr_q) begin
                val_d   = DATA_W'(k_q) + DATA_W'(2);
                ndig_d  = '0;
                state_d = S_HDR_CONV;
              end else begin
                state_d = S_RD_REQ;
              end
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything and never produces a done pulse.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      base_q  <= '0;
      count_q <= '0;
      pad_q   <= '0;
      hdr_q   <= 1'b0;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      val_q   <= '0;
      ndig_q  <= '0;
      pcnt_q  <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MAT_FMT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      base_q  <= base_d;
      count_q <= count_d;
      pad_q   <= pad_d;
      hdr_q   <= hdr_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      val_q   <= val_d;
      ndig_q  <= ndig_d;
      pcnt_q  <= pcnt_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MAT_FMT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Digit buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the digit buffer; each entry is written by CONV
    // before DIGIT can read it.
    dig_q <= dig_d;
  end

endmodule

// File: tb/tb_mat_fmt_streamer.sv
// Directed self-checking bench for mat_fmt_streamer (default parameters,
// one-cycle registered storage model).
module tb_mat_fmt_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  cfg_rows = '0;
  logic [4:0]  cfg_cols = '0;
  logic [8:0]  cfg_base = '0;
  logic [1:0]  cfg_count = '0;
  logic [3:0]  cfg_pad = '0;
  logic        cfg_hdr = 1'b0;
  logic        mem_rd_en;
  logic [8:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy, done, err;

  mat_fmt_streamer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base(cfg_base),
    .cfg_count(cfg_count), .cfg_pad(cfg_pad), .cfg_hdr(cfg_hdr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Storage model with one cycle of read latency.
  logic [31:0] mem [512];
  logic [31:0] rdata = '0;
  always @(posedge clk) if (mem_rd_en) rdata <= mem[mem_rd_addr];
  assign mem_rd_data = rdata;

  // Sink: fixed level or random backpressure, changed just after each edge.
  logic ready_level = 1'b0;
  logic bp_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Monitor, sampling mid-cycle.
  logic [7:0] rx_q [$];
  int         rd_q [$];
  int         rd_cyc_q [$];
  int         done_cnt = 0, valid_cnt = 0, done_cyc = -1, last_tx_cyc = -1;
  logic       done_err = 1'b0, done_busy = 1'b0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = '0;
  int         start_cyc = 0;
  string      crlf;

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        tests++;
        if (!tx_valid || tx_data !== stall_data) begin
          fails++;
          $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                   tx_valid, tx_data, stall_data);
        end
      end
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid) valid_cnt++;
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        last_tx_cyc = cyc;
      end
      if (mem_rd_en) begin
        rd_q.push_back(int'(mem_rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_err  = err;
        done_busy = busy;
      end
    end
  end

  function automatic string rx_raw();
    string s = "";
    foreach (rx_q[i]) s = $sformatf("%s%c", s, rx_q[i]);
    return s;
  endfunction

  function automatic string esc(string s);
    string t = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'd13)      t = {t, "\\r"};
      else if (s[i] == 8'd10) t = {t, "\\n"};
      else                    t = $sformatf("%s%c", t, s[i]);
    end
    return t;
  endfunction

  function automatic string addr_list();
    string s = "";
    foreach (rd_q[i]) s = (i == 0) ? $sformatf("%0d", rd_q[i]) : $sformatf("%s %0d", s, rd_q[i]);
    return s;
  endfunction

  // Issue a start with the given configuration, then scramble cfg_* so
  // that only the latched copy can produce the right result.
  task automatic start_op(input int rows, input int cols, input int base,
                          input int count, input int pad, input bit hdr);
    rx_q.delete();
    rd_q.delete();
    rd_cyc_q.delete();
    @(posedge clk);
    #1;
    cfg_rows  = 5'(rows);
    cfg_cols  = 5'(cols);
    cfg_base  = 9'(base);
    cfg_count = 2'(count);
    cfg_pad   = 4'(pad);
    cfg_hdr   = hdr;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    cfg_rows  = '1;
    cfg_cols  = '1;
    cfg_base  = 9'd300;
    cfg_count = '1;
    cfg_pad   = '1;
    cfg_hdr   = ~hdr;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done within 3000 cycles", name);
    end
  endtask

  task automatic test_reset();
    logic [21:0] got;
    repeat (3) @(posedge clk);
    #2;
    got = {tx_valid, tx_data, mem_rd_en, mem_rd_addr, busy, done, err};
    tests++;
    if (got !== 22'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %06h, required 000000", got);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_unsigned();
    string exp;
    mem[0] = 32'd1; mem[1] = 32'd23; mem[2] = 32'd0; mem[3] = 32'hFFFF_FFFF;
    ready_level = 1'b1;
    start_op(2, 2, 0, 1, 0, 1'b0);
    wait_done("unsigned");
    exp = {"1 23", crlf, "0 4294967295", crlf};
    tests++;
    if (rx_raw() != exp) begin
      fails++;
      $display("FAIL unsigned_stream: got \"%s\", required \"%s\"", esc(rx_raw()), esc(exp));
    end
    tests++;
    if (addr_list() != "0 1 2 3") begin
      fails++;
      $display("FAIL unsigned_addrs: got \"%s\", required \"0 1 2 3\"", addr_list());
    end
    tests++;
    if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != start_cyc) begin
      fails++;
      $display("FAIL first_read_cycle: got %0d, required %0d",
               (rd_cyc_q.size() == 0) ? -1 : rd_cyc_q[0], start_cyc);
    end
    tests++;
    if (done_err !== 1'b0 || done_busy !== 1'b0) begin
      fails++;
      $display("FAIL unsigned_done_flags: err=%0b busy=%0b, required err=0 busy=0", done_err, done_busy);
    end
    tests++;
    if (done_cyc != last_tx_cyc + 1) begin
      fails++;
      $display("FAIL done_timing: done cycle %0d, required %0d", done_cyc, last_tx_cyc + 1);
    end
  endtask

  task automatic test_hdr_pad();
    string exp;
    mem[10] = 32'd7; mem[11] = 32'd123; mem[12] = 32'd4567;
    mem[13] = 32'd0; mem[14] = 32'd89;  mem[15] = 32'd1000;
    ready_level = 1'b1;
    start_op(1, 3, 10, 2, 3, 1'b1);
    wait_done("hdr_pad");
    exp = {"1", crlf, "  7 123 4567", crlf, "2", crlf, "  0  89 1000", crlf};
    tests++;
    if (rx_raw() != exp) begin
      fails++;
      $display("FAIL hdr_pad_stream: got \"%s\", required \"%s\"", esc(rx_raw()), esc(exp));
    end
    tests++;
    if (addr_list() != "10 11 12 13 14 15") begin
      fails++;
      $display("FAIL hdr_pad_addrs: got \"%s\", required \"10 11 12 13 14 15\"", addr_list());
    end
    tests++;
    if (done_err !== 1'b0) begin
      fails++;
      $display("FAIL hdr_pad_err: got %0b, required 0", done_err);
    end
  endtask

`ifdef MAT_FMT_SIGNED_EN
  task automatic test_signed();
    string exp;
    mem[20] = 32'hFFFF_FFFB; mem[21] = 32'h8000_0000;
    ready_level = 1'b1;
    start_op(1, 2, 20, 1, 4, 1'b0);
    wait_done("signed");
    exp = {"  -5 -2147483648", crlf};
    tests++;
    if (rx_raw() != exp) begin
      fails++;
      $display("FAIL signed_stream: got \"%s\", required \"%s\"", esc(rx_raw()), esc(exp));
    end
  endtask
`endif

  task automatic test_backpressure();
    string exp;
    mem[30] = 32'd5;   mem[31] = 32'd10; mem[32] = 32'd99;
    mem[33] = 32'd100; mem[34] = 32'd0;  mem[35] = 32'd65535;
    bp_mode = 1'b1;
    start_op(2, 3, 30, 1, 2, 1'b1);
    wait_done("backpressure");
    bp_mode = 1'b0;
    exp = {"1", crlf, " 5 10 99", crlf, "100  0 65535", crlf};
    tests++;
    if (rx_raw() != exp) begin
      fails++;
      $display("FAIL bp_stream: got \"%s\", required \"%s\"", esc(rx_raw()), esc(exp));
    end
  endtask

  task automatic test_zero_and_busy_start();
    int v0, d0;
    string exp;
    ready_level = 1'b1;
    v0 = valid_cnt;
    start_op(2, 0, 0, 1, 0, 1'b0);
    wait_done("zero_dim");
    tests++;
    if (done_cyc != start_cyc + 1 || done_err !== 1'b1) begin
      fails++;
      $display("FAIL zero_dim_done: cycle %0d err=%0b, required cycle %0d err=1",
               done_cyc, done_err, start_cyc + 1);
    end
    tests++;
    if (valid_cnt != v0) begin
      fails++;
      $display("FAIL zero_dim_bytes: %0d valid cycles, required 0", valid_cnt - v0);
    end

    // Start while busy: stall the sink, then request a zero-size job.
    mem[40] = 32'd7;
    ready_level = 1'b0;
    d0 = done_cnt;
    start_op(1, 1, 40, 1, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    cfg_cols = '0;
    cfg_base = '0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    ready_level = 1'b1;
    wait_done("busy_start");
    repeat (5) @(posedge clk);
    exp = {"7", crlf};
    tests++;
    if (rx_raw() != exp) begin
      fails++;
      $display("FAIL busy_start_stream: got \"%s\", required \"%s\"", esc(rx_raw()), esc(exp));
    end
    tests++;
    if (done_cnt - d0 != 1 || done_err !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_done: %0d pulses err=%0b, required 1 pulse err=0",
               done_cnt - d0, done_err);
    end
    tests++;
    if (rd_q.size() != 1) begin
      fails++;
      $display("FAIL busy_start_reads: got %0d reads, required 1", rd_q.size());
    end
  endtask

  task automatic test_abort();
    int d0;
    mem[50] = 32'd123456;
    ready_level = 1'b1;
    d0 = done_cnt;
    start_op(1, 1, 50, 1, 0, 1'b0);
    for (int i = 0; i < 200 && rx_q.size() < 2; i++) @(posedge clk);
    tests++;
    if (rx_q.size() < 2) begin
      fails++;
      $display("FAIL abort_reach_digit: got %0d bytes, required 2", rx_q.size());
    end
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%0b tx_valid=%0b, required 0 0", busy, tx_valid);
    end
    repeat (10) @(posedge clk);
    tests++;
    if (done_cnt != d0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    tests++;
    if (rx_raw() != "123") begin
      fails++;
      $display("FAIL abort_bytes: got \"%s\", required \"123\"", esc(rx_raw()));
    end
  endtask

  task automatic test_reset_mid_read();
    logic [21:0] got;
    start_op(1, 1, 60, 1, 0, 1'b0);
    tests++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 9'd60) begin
      fails++;
      $display("FAIL pre_reset_read: rd_en=%0b addr=%0d, required 1 60", mem_rd_en, mem_rd_addr);
    end
    #2 rst = 1'b1;
    #1;
    got = {tx_valid, tx_data, mem_rd_en, mem_rd_addr, busy, done, err};
    tests++;
    if (got !== 22'h0) begin
      fails++;
      $display("FAIL async_reset_outputs: got %06h, required 000000", got);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    crlf = $sformatf("%c%c", 8'd13, 8'd10);
    foreach (mem[i]) mem[i] = 32'd0;
    test_reset();
    test_unsigned();
    test_hdr_pad();
`ifdef MAT_FMT_SIGNED_EN
    test_signed();
`endif
    test_backpressure();
    test_zero_and_busy_start();
    test_abort();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
